// File: rtl/video_timing_pkg.sv
// Shared timing defaults and lock-state encoding for video timing users.
// Holds the standard 1024x768 raster numbers so every consumer agrees on them.
// Pure declarations; no logic lives here.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 144;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_CNT_W    = 12;

  // Stream-to-raster lock state: searching for SOF, holding SOF, streaming.
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running x/y counters plus sync/blank/active decode.
// Latency: decoded outputs are registered one cycle after the (x,y) they describe;
// active_early is combinational from x,y so the consumer can request that pixel in time.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active_early,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             active_video
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] X_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] X_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] Y_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] Y_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_TOTAL - 1);

  logic hb_c;
  logic vb_c;
  logic hs_c;
  logic vs_c;

  // Raster position runs freely; y steps when x wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (x == X_LAST) begin
      x <= '0;
      y <= (y == Y_LAST) ? '0 : y + CNT_W'(1);
    end else begin
      x <= x + CNT_W'(1);
    end
  end

  // Region decode of the current position: active, front porch, sync, back porch.
  always_comb begin
    hb_c = (x >= X_ACT_END);
    vb_c = (y >= Y_ACT_END);
    hs_c = (x >= X_SYNC_BEG) && (x < X_SYNC_END);
    vs_c = (y >= Y_SYNC_BEG) && (y < Y_SYNC_END);
  end

  assign active_early = !hb_c && !vb_c;

  // Timing outputs registered so they line up with the registered pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      hblank       <= 1'b0;
      vblank       <= 1'b0;
      active_video <= 1'b0;
    end else begin
      hsync        <= hs_c ? HS_POL : ~HS_POL;
      vsync        <= vs_c ? VS_POL : ~VS_POL;
      hblank       <= hb_c;
      vblank       <= vb_c;
      active_video <= active_early;
    end
  end

endmodule

// File: rtl/axis_video_timing_out.sv
// AXI-Stream to parallel video: locks the stream to the raster on SOF and checks line alignment.
// Latency: pixel and timing for a given (x,y) leave together, one cycle after (x,y).
// Backpressure: s_tready follows the raster's active region; the raster itself never stalls.
module axis_video_timing_out
  import video_timing_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                R_W      = 5,
  parameter int                G_W      = 6,
  parameter int                B_W      = 5,
  parameter int                H_ACTIVE = DEF_H_ACTIVE,
  parameter int                H_FP     = DEF_H_FP,
  parameter int                H_SYNC   = DEF_H_SYNC,
  parameter int                H_BP     = DEF_H_BP,
  parameter int                V_ACTIVE = DEF_V_ACTIVE,
  parameter int                V_FP     = DEF_V_FP,
  parameter int                V_SYNC   = DEF_V_SYNC,
  parameter int                V_BP     = DEF_V_BP,
  parameter logic              HS_POL   = 1'b1,
  parameter logic              VS_POL   = 1'b1,
  parameter logic [DATA_W-1:0] FILL     = '0,
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tuser,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [R_W-1:0]    video_r,
  output logic [G_W-1:0]    video_g,
  output logic [B_W-1:0]    video_b,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              active_video,
  output logic              locked,
  output logic              underflow,
  output logic              line_err,
  input  logic              clr_status
);

  localparam logic [CNT_W-1:0] X_LAST_ACT = CNT_W'(H_ACTIVE - 1);

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             act_early;
  lock_state_t      state;
  logic [DATA_W-1:0] pix;

  logic at_origin;
  logic run_now;
  logic sof_beat;
  logic show_beat;
  logic starve;
  logic misalign;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .active_early (act_early),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank),
    .active_video (active_video)
  );

  // ARMED releases its held SOF beat at (0,0) itself, so that cycle already behaves as RUN
  // and the first pixel of the frame is not lost.
  always_comb begin
    at_origin = (x == '0) && (y == '0);
    run_now   = (state == RUN) || ((state == ARMED) && at_origin);
    sof_beat  = s_tvalid && s_tuser;
    show_beat = run_now && act_early && s_tvalid;
    starve    = run_now && act_early && !s_tvalid;
    misalign  = show_beat &&
                ((s_tlast != (x == X_LAST_ACT)) || (s_tuser != at_origin));
  end

  // Ready: open while hunting (except on the SOF beat), raster-active while streaming.
  always_comb begin
    s_tready = 1'b0;
    if (reset_n) begin
      case (state)
        HUNT:       s_tready = !sof_beat;
        ARMED, RUN: s_tready = run_now && act_early;
        default:    s_tready = 1'b0;
      endcase
    end
  end

  // Lock FSM with its registered pixel, lock indication and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      pix       <= '0;
      locked    <= 1'b0;
      underflow <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      pix       <= show_beat ? s_tdata : FILL;
      locked    <= run_now;
      underflow <= starve | (underflow & ~clr_status);
      line_err  <= misalign | (line_err & ~clr_status);
      if (run_now) begin
        state <= (starve || misalign) ? HUNT : RUN;
      end else if ((state == HUNT) && sof_beat) begin
        state <= ARMED;
      end
    end
  end

  assign video_r = pix[DATA_W-1 -: R_W];
  assign video_g = pix[B_W +: G_W];
  assign video_b = pix[B_W-1:0];

endmodule

// File: tb/tb_axis_video_timing_out.sv
module tb_axis_video_timing_out;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b1;
  localparam logic [15:0] FILL = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] s_tdata;
  logic        s_tuser, s_tlast, s_tvalid, s_tready, clr_status;
  logic [4:0]  video_r, video_b;
  logic [5:0]  video_g;
  logic        hsync, vsync, hblank, vblank, active_video, locked, underflow, line_err;

  // second instance at the default 1024x768 timing, stream idle
  logic [15:0] d_tdata = 16'h0000;
  logic        d_tin = 1'b0;
  logic        d_tready, d_hsync, d_vsync, d_hblank, d_vblank, d_active, d_locked, d_uf, d_le;
  logic [4:0]  d_r, d_b;
  logic [5:0]  d_g;

  axis_video_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .FILL(FILL), .CNT_W(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .video_r(video_r), .video_g(video_g),
    .video_b(video_b), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .active_video(active_video), .locked(locked), .underflow(underflow),
    .line_err(line_err), .clr_status(clr_status)
  );

  axis_video_timing_out dut_def (
    .clk(clk), .reset_n(reset_n), .s_tdata(d_tdata), .s_tuser(d_tin), .s_tlast(d_tin),
    .s_tvalid(d_tin), .s_tready(d_tready), .video_r(d_r), .video_g(d_g),
    .video_b(d_b), .hsync(d_hsync), .vsync(d_vsync), .hblank(d_hblank), .vblank(d_vblank),
    .active_video(d_active), .locked(d_locked), .underflow(d_uf),
    .line_err(d_le), .clr_status(d_tin)
  );

  int n_vec = 0;
  int n_err = 0;
  bit def_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: raster position, lock mode (0 search, 1 waiting, 2 streaming), expected outputs
  int mx, my, mode, ox, oy;
  logic [15:0] e_pix;
  logic [4:0]  e_tim;   // {hsync, vsync, hblank, vblank, active}
  logic [2:0]  e_stat;  // {locked, underflow, line_err}

  // source: frames of HA x VA pixels, with injectable faults
  int sx, sy;
  bit have, cuser, clast, src_en, pin_en, force_clr;
  logic [15:0] cdat;
  int p_drop, p_last, p_user, p_clr;
  int drop_x = -1, drop_y = -1, bad_last_sx = -1;

  // independent checks on the DUT waveforms
  int cyc, last_hfall, last_vfall, pin_hits;
  bit prev_hb, prev_vb, prev_lock;

  task automatic do_reset();
    reset_n = 1'b0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0; clr_status = 1'b0;
    #1;
    chk("rst_hsync", 32'(hsync), 32'(1'b1));
    chk("rst_vsync", 32'(vsync), 32'(1'b0));
    chk("rst_blank", 32'({hblank, vblank, active_video}), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_status", 32'({locked, underflow, line_err}), 32'd0);
    chk("rst_rgb", 32'({video_r, video_g, video_b}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mx = 0; my = 0; mode = 0;
    e_pix = '0; e_tim = {~HSP, ~VSP, 3'b000}; e_stat = 3'b000;
    sx = 0; sy = 0; have = 1'b0;
    last_hfall = -1; last_vfall = -1; prev_hb = 1'b0; prev_vb = 1'b0; prev_lock = 1'b0;
  endtask

  task automatic cycle();
    bit drop, run, act, mrdy, ufs, les, acc;
    int nmode;
    logic [15:0] pix;
    // drive source
    if (src_en && !have) begin
      cdat = 16'($urandom);
      if (pin_en && sx == 5 && sy == 3) cdat = 16'hF81F;
      cuser = (sx == 0 && sy == 0);
      clast = (sx == HA - 1);
      if ($urandom_range(99) < p_last) clast = !clast;
      if ($urandom_range(99) < p_user) cuser = !cuser;
      if (bad_last_sx >= 0 && sx == bad_last_sx) begin clast = 1'b1; bad_last_sx = -1; end
      have = 1'b1;
    end
    drop = ($urandom_range(99) < p_drop);
    if (mode == 2 && mx == drop_x && my == drop_y) begin drop = 1'b1; drop_x = -1; end
    s_tvalid = have && !drop;
    s_tdata = cdat; s_tuser = cuser; s_tlast = clast;
    clr_status = ($urandom_range(99) < p_clr) || force_clr;
    force_clr = 1'b0;
    #1;
    // model this cycle
    run  = (mode == 2) || (mode == 1 && mx == 0 && my == 0);
    act  = (mx < HA) && (my < VA);
    mrdy = (mode == 0) ? !(s_tvalid && s_tuser) : (run && act);
    chk("tready", 32'(s_tready), 32'(mrdy));
    pix = FILL; ufs = 1'b0; les = 1'b0; nmode = mode;
    if (run) begin
      nmode = 2;
      if (act) begin
        if (s_tvalid) begin
          pix = s_tdata;
          if ((s_tlast != (mx == HA - 1)) || (s_tuser != (mx == 0 && my == 0))) begin
            les = 1'b1; nmode = 0;
          end
        end else begin
          ufs = 1'b1; nmode = 0;
        end
      end
    end else if (mode == 0 && s_tvalid && s_tuser) begin
      nmode = 1;
    end
    e_pix  = pix;
    e_tim  = {(mx >= HA + HF && mx < HA + HF + HS) ? HSP : ~HSP,
              (my >= VA + VF && my < VA + VF + VS) ? VSP : ~VSP,
              mx >= HA, my >= VA, act};
    e_stat = {run, ufs | (e_stat[1] & ~clr_status), les | (e_stat[0] & ~clr_status)};
    ox = mx; oy = my; mode = nmode;
    mx++;
    if (mx == HT) begin mx = 0; my++; if (my == VT) my = 0; end
    acc = s_tvalid && s_tready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (acc) begin
      have = 1'b0;
      sx++;
      if (sx == HA) begin sx = 0; sy++; if (sy == VA) sy = 0; end
    end
    // compare registered outputs
    chk("timing", 32'({hsync, vsync, hblank, vblank, active_video}), 32'(e_tim));
    chk("pixel", 32'({video_r, video_g, video_b}), 32'(e_pix));
    chk("status", 32'({locked, underflow, line_err}), 32'(e_stat));
    chk("hsync_lit", 32'(hsync), (ox == 10 || ox == 11) ? 32'd0 : 32'd1);
    if (pin_en && ox == 5 && oy == 3 && e_stat[2]) begin
      chk("pix53_r", 32'(video_r), 32'h1F);
      chk("pix53_g", 32'(video_g), 32'h00);
      chk("pix53_b", 32'(video_b), 32'h1F);
      pin_hits++;
    end
    if (prev_hb && !hblank) begin
      if (last_hfall >= 0) chk("h_total", cyc - last_hfall, 14);
      last_hfall = cyc;
    end
    if (prev_vb && !vblank) begin
      if (last_vfall >= 0) chk("v_total", cyc - last_vfall, 98);
      last_vfall = cyc;
    end
    if (locked && !prev_lock) chk("lock_origin", ox * 100 + oy, 0);
    prev_hb = hblank; prev_vb = vblank; prev_lock = locked;
  endtask

  // default-timing raster: first hsync must appear for x=1048 of line 0
  initial begin : default_timing
    int first_hs, hs_fall, first_hb;
    first_hs = -1; hs_fall = -1; first_hb = -1;
    @(posedge reset_n);
    for (int n = 1; n <= 1300; n++) begin
      @(negedge clk);
      if (d_hsync === 1'b1 && first_hs < 0) first_hs = n;
      if (d_hsync === 1'b0 && first_hs >= 0 && hs_fall < 0) hs_fall = n;
      if (d_hblank === 1'b1 && first_hb < 0) first_hb = n;
    end
    chk("def_first_hsync", first_hs, 1049);
    chk("def_hsync_end", hs_fall, 1185);
    chk("def_first_hblank", first_hb, 1025);
    chk("def_unlocked", 32'(d_locked), 32'd0);
    def_done = 1'b1;
  end

  initial begin
    int i;
    reset_n = 1'b0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0; clr_status = 1'b0;
    src_en = 1'b0; pin_en = 1'b0; force_clr = 1'b0;
    p_drop = 0; p_last = 0; p_user = 0; p_clr = 0;
    cyc = 0; pin_hits = 0;
    @(negedge clk);
    do_reset();

    // clean frames
    src_en = 1'b1; pin_en = 1'b1;
    repeat (3 * HT * VT) cycle();
    chk("t2_pin_seen", 32'(pin_hits != 0), 32'd1);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_flags", 32'({underflow, line_err}), 32'd0);
    pin_en = 1'b0;

    // single missing beat
    drop_x = 3; drop_y = 2;
    for (i = 0; i < 300 && drop_x != -1; i++) cycle();
    chk("t3_drop_hit", drop_x, -1);
    chk("t3_fill", 32'({video_r, video_g, video_b}), 32'(FILL));
    chk("t3_underflow", 32'(underflow), 32'd1);
    cycle();
    chk("t3_unlocked", 32'(locked), 32'd0);
    for (i = 0; i < 400 && !locked; i++) cycle();
    chk("t3_relock", 32'(locked), 32'd1);

    // short line
    force_clr = 1'b1;
    cycle();
    chk("t4_uf_cleared", 32'(underflow), 32'd0);
    bad_last_sx = HA - 2;
    for (i = 0; i < 300 && !line_err; i++) cycle();
    chk("t4_line_err", 32'(line_err), 32'd1);
    force_clr = 1'b1;
    cycle();
    chk("t4_clr", 32'(line_err), 32'd0);
    for (i = 0; i < 400 && !locked; i++) cycle();
    chk("t4_relock", 32'(locked), 32'd1);

    // randomized faults and clears
    p_drop = 3; p_last = 1; p_user = 1; p_clr = 4;
    repeat (4000) cycle();
    p_drop = 0; p_last = 0; p_user = 0; p_clr = 0;

    // mid-frame reset, then a late first SOF
    repeat (5) cycle();
    src_en = 1'b0;
    do_reset();
    for (i = 0; i < 200 && my != 3; i++) cycle();
    src_en = 1'b1;
    repeat (3) cycle();
    chk("t5_armed_tready", 32'(s_tready), 32'd0);
    chk("t5_armed_unlocked", 32'(locked), 32'd0);
    for (i = 0; i < 200 && !locked; i++) cycle();
    chk("t5_locked", 32'(locked), 32'd1);
    repeat (HT * VT) cycle();

    for (i = 0; i < 2000 && !def_done; i++) @(negedge clk);
    chk("default_done", 32'(def_done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
